alu_cc_unit: RTL
================

Name: alu_cc_unit

Overview:
Execute stage directly downstream of the register file in the SLC-3.2 datapath. Consumes sr1out/sr2out plus IR immediate fields and produces a registered ALU result for the bus gate.
Holds the NZP condition-code register, loaded from the bus, and the BEN branch-enable flag.
Adds a multi-cycle shift-add MUL so the 8-bit multiplier work carries into the 16-bit datapath.

Parameters:
WIDTH, 16, datapath width; imm5 field position ir[4:0] and ir[5] select are fixed.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
sr1out  input  WIDTH  operand A from register file
sr2out  input  WIDTH  operand B source from register file
ir  input  WIDTH  instruction register (ir[5] imm select, ir[4:0] imm5, ir[11:9] nzp mask)
aluk  input  3  op: 000 ADD, 001 AND, 010 NOT A, 011 PASS A, 100 MUL, 101-111 reserved
op_valid  input  1  request to execute aluk on current operands
op_ready  output  1  unit can accept an op this cycle
result_valid  output  1  one-cycle pulse: alu_out holds a new result
alu_out  output  WIDTH  registered result (to GateALU)
bus  input  WIDTH  datapath bus, source for condition codes
ld_cc  input  1  load NZP from bus
ld_ben  input  1  load BEN
nzp  output  3  condition codes {N,Z,P}
ben  output  1  branch enable

Behaviour:
- Reset values: alu_out=0, result_valid=0, op_ready=1, nzp=3'b010, ben=0, FSM=IDLE. Reset asserted mid-MUL aborts it; no result_valid is produced for the aborted op.
- Operand B = ir[5] ? sign-extend(ir[4:0]) : sr2out. A = sr1out. Both are sampled only at the accepting edge.
- Accept happens at an edge when op_valid && op_ready. An op_valid edge with op_ready=0 is ignored, not queued.
- FSM states IDLE, MUL_RUN. op_ready = (state==IDLE).
- ADD/AND/NOT/PASS/reserved: single cycle, with FSM staying in IDLE.
  - Accept at edge E0 writes alu_out and sets result_valid for the following cycle.
  - ADD is modulo 2^WIDTH with carry discarded. NOT is bitwise ~A. Reserved codes give 0.
  - Back-to-back single-cycle ops are accepted every cycle.
- MUL: IDLE->MUL_RUN at accept E0.
  - Latch multiplicand=A, multiplier=B, acc=0, count=0.
  - Each edge E1..E16 processes one multiplier bit: if the LSB is set, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - At E16 (count reaches 15->16): alu_out <= final acc, which is the low WIDTH bits of the unsigned product (two's-complement correct in the low half). Also result_valid <= 1 and state -> IDLE.
  - op_ready is low after E0 through E16. The next op can be accepted at E16+1.
  - alu_out keeps its previous value during MUL_RUN.
- result_valid is high for exactly one cycle per accepted op. Otherwise it is 0.
- NZP: on ld_cc edge, nzp <= bus[WIDTH-1] ? 100 : (bus==0 ? 010 : 001). Otherwise it holds. Exactly one bit is always set.
- BEN: on ld_ben edge, ben <= |(ir[11:9] & nzp) using the pre-edge nzp. When ld_cc and ld_ben are on the same edge, ben uses the old nzp. Otherwise ben holds.
- ld_cc/ld_ben operate independently of the ALU FSM, including during MUL_RUN.

Optional Feature:
ALU_MUL_EN
- Defined: MUL op and MUL_RUN state built as above.
- Undefined: no multiplier registers or FSM. aluk=100 executes as PASS A in one cycle, and op_ready is tied to 1.

Test Plan:
- ADD reg: ir[5]=0, sr1out=0x0005, sr2out=0xFFFD, op_valid 1 cycle -> next cycle alu_out=0x0002, result_valid=1 for exactly 1 cycle.
- ADD imm / NOT: ir[5]=1, ir[4:0]=5'b10000, sr1out=0x0010 -> alu_out=0x0000. Then NOT on 0x00FF -> 0xFF00 on consecutive cycles, two result_valid pulses.
- MUL: sr1out=0x0012, sr2out=0x0034, aluk=100 -> op_ready low 16 cycles, then alu_out=0x03A8 with result_valid pulse. op_valid asserted while busy is ignored.
- MUL wrap: 0xFFFF*0x0003 -> 0xFFFD; 0x0100*0x0100 -> 0x0000.
- CC/BEN: bus=0x8000 with ld_cc -> nzp=100. Starting from reset nzp=010 with ir[11:9]=010, simultaneous ld_cc(bus=0x8000)+ld_ben -> ben=1, nzp=100. Then bus=0x0000 ld_cc -> nzp=010.
- Reset mid-MUL: drop reset at iteration 8 -> alu_out=0, nzp=010, ben=0, op_ready=1 immediately, and no result_valid after release.

Source files
------------

// File: rtl/alu_cc_unit_if.sv
// alu_cc_unit_if: operand/result handshake and condition-code bus
// master drives operands and CC loads; slave is the execute unit
interface alu_cc_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sr1out;
  logic [WIDTH-1:0] sr2out;
  logic [WIDTH-1:0] ir;
  logic [2:0]       aluk;
  logic             op_valid;
  logic             op_ready;
  logic             result_valid;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] bus;
  logic             ld_cc;
  logic             ld_ben;
  logic [2:0]       nzp;
  logic             ben;

  modport master (
    output sr1out, sr2out, ir, aluk, op_valid,
    output bus, ld_cc, ld_ben,
    input  op_ready, result_valid, alu_out, nzp, ben
  );

  modport slave (
    input  sr1out, sr2out, ir, aluk, op_valid,
    input  bus, ld_cc, ld_ben,
    output op_ready, result_valid, alu_out, nzp, ben
  );
endinterface

// File: rtl/alu_cc_unit.sv
// alu_cc_unit: execute-stage ALU, NZP/BEN flags, optional shift-add MUL
// ALU_MUL_EN builds the multi-cycle multiplier; otherwise MUL acts as PASS A
module alu_cc_unit #(
  parameter int WIDTH = 16
) (
  input logic        clk,
  input logic        reset,
  alu_cc_unit_if.slave io
);

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] wr_val;
  logic             accept;
  logic             wr;

  assign opa = io.sr1out;
  assign opb = io.ir[5] ? {{(WIDTH-5){io.ir[4]}}, io.ir[4:0]}
                        : io.sr2out;
  assign accept = io.op_valid && io.op_ready;

  // single-cycle op result
  always_comb begin
    res = '0;
    unique case (io.aluk)
      3'b000:  res = opa + opb;
      3'b001:  res = opa & opb;
      3'b010:  res = ~opa;
      3'b011:  res = opa;
`ifndef ALU_MUL_EN
      3'b100:  res = opa;
`endif
      default: res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    count;
  logic             start;
  logic             done;

  assign io.op_ready = (state == IDLE);
  assign start   = accept && (io.aluk == 3'b100);
  assign acc_nxt = acc + (mplr[0] ? mcand : '0);
  assign done    = (state == MUL_RUN) && (count == CW'(WIDTH - 1));
  assign wr      = done || (accept && !start);
  assign wr_val  = done ? acc_nxt : res;

  // next-state: run one bit per cycle until the last multiplier bit
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = MUL_RUN;
      MUL_RUN: if (done)  state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // shift-add datapath: latch on start, step while running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      count <= '0;
    end else if (start) begin
      mcand <= opa;
      mplr  <= opb;
      acc   <= '0;
      count <= '0;
    end else if (state == MUL_RUN) begin
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      count <= count + CW'(1);
    end
  end
`else
  assign io.op_ready = 1'b1;
  assign wr     = accept;
  assign wr_val = res;
`endif

  // result register and one-cycle valid pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io.alu_out      <= '0;
      io.result_valid <= 1'b0;
    end else begin
      io.result_valid <= wr;
      if (wr) io.alu_out <= wr_val;
    end
  end

  // condition codes; ben sees the nzp from before this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io.nzp <= 3'b010;
      io.ben <= 1'b0;
    end else begin
      if (io.ld_cc) begin
        if (io.bus[WIDTH-1])   io.nzp <= 3'b100;
        else if (io.bus == '0) io.nzp <= 3'b010;
        else                   io.nzp <= 3'b001;
      end
      if (io.ld_ben) io.ben <= |(io.ir[11:9] & io.nzp);
    end
  end

endmodule
